// File: rtl/dtw_result_pkg.sv
// Shared types and constants for the DTW result collector.
package dtw_result_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        SEND   = 2'd2
    } state_t;

    localparam int unsigned RECORD_WORDS = 3;

    localparam int unsigned W_QID    = 0;
    localparam int unsigned W_POS    = 1;
    localparam int unsigned W_MINVAL = 2;

endpackage

// File: rtl/dtw_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module dtw_rr_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned SEL_WIDTH = 4
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [SEL_WIDTH-1:0] rr_ptr,
    output logic [SEL_WIDTH-1:0] grant,
    output logic                 any_req
);

    logic [2*NUM_CORES-1:0] req_dbl;
    logic [NUM_CORES-1:0]   req_rot;

    // Rotate requests so bit 0 is rr_ptr, then take the lowest set bit.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        req_dbl = {req, req};
        req_rot = NUM_CORES'(req_dbl >> rr_ptr);
        grant   = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!any_req && req_rot[i]) begin
                any_req = 1'b1;
                idx     = 32'(rr_ptr) + i;
                if (idx >= NUM_CORES) begin
                    idx = idx - NUM_CORES;
                end
                grant = SEL_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/dtw_result_collector.sv
// Drains per-core 3-word result FIFOs round-robin onto one AXI-Stream master.
// Optional score filter enabled by defining DTW_RESULT_FILTER_EN.
module dtw_result_collector
    import dtw_result_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned AXIS_WIDTH = 32,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SEL_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CORES-1:0]            res_fifo_empty,
    output logic [NUM_CORES-1:0]            res_fifo_rden,
    input  logic [NUM_CORES*AXIS_WIDTH-1:0] res_fifo_data,
    input  logic [WIDTH-1:0]                score_threshold,
    output logic [AXIS_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [1:0]                      dbg_state,
    output logic [SEL_WIDTH-1:0]            dbg_sel,
    output logic [31:0]                     dbg_nrecords,
    output logic [31:0]                     dbg_ndropped
);

    state_t                 state, state_nxt;
    logic [SEL_WIDTH-1:0]   rr_ptr, sel, grant, ptr_after_sel;
    logic                   any_req;
    logic [1:0]             widx, ridx;
    logic [AXIS_WIDTH-1:0]  rec_buf [RECORD_WORDS];
    logic [NUM_CORES-1:0]   sel_onehot;
    logic [AXIS_WIDTH-1:0]  pop_data;
    logic                   pop, last_pop, drop, beat_done, rec_done;

    dtw_rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arb (
        .req     (~res_fifo_empty),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    // Pop only the locked core, and only while it has data; mux its word.
    always_comb begin
        sel_onehot    = NUM_CORES'(1) << sel;
        res_fifo_rden = '0;
        pop_data      = '0;
        if (state == GATHER) begin
            res_fifo_rden = sel_onehot & ~res_fifo_empty;
        end
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (sel_onehot[i]) begin
                pop_data = res_fifo_data[i*AXIS_WIDTH +: AXIS_WIDTH];
            end
        end
    end

    assign pop           = |res_fifo_rden;
    assign last_pop      = pop && (widx == 2'(W_MINVAL));
    assign beat_done     = m_axis_tvalid && m_axis_tready;
    assign rec_done      = (state == SEND) && beat_done && (ridx == 2'(W_MINVAL));
    assign ptr_after_sel = (32'(sel) >= NUM_CORES - 1) ? '0 : sel + SEL_WIDTH'(1);
    assign dbg_state     = 2'(state);
    assign dbg_sel       = sel;

`ifdef DTW_RESULT_FILTER_EN
    assign drop = pop_data[WIDTH-1:0] > score_threshold;
`else
    logic unused_threshold;
    assign unused_threshold = ^score_threshold;
    assign drop = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req)  state_nxt = GATHER;
            GATHER:  if (last_pop) state_nxt = drop ? IDLE : SEND;
            SEND:    if (rec_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, record capture, beat sequencing and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            sel           <= '0;
            widx          <= '0;
            ridx          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            dbg_nrecords  <= '0;
            dbg_ndropped  <= '0;
            for (int unsigned i = 0; i < RECORD_WORDS; i++) begin
                rec_buf[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        sel  <= grant;
                        widx <= '0;
                    end
                end
                GATHER: begin
                    if (pop) begin
                        rec_buf[widx] <= pop_data;
                        widx          <= widx + 2'd1;
                    end
                    if (last_pop) begin
                        widx <= '0;
                        if (drop) begin
                            rr_ptr       <= ptr_after_sel;
                            dbg_ndropped <= dbg_ndropped + 32'd1;
                        end else begin
                            ridx          <= '0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= rec_buf[W_QID];
                        end
                    end
                end
                SEND: begin
                    if (beat_done) begin
                        if (ridx == 2'(W_MINVAL)) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            rr_ptr        <= ptr_after_sel;
                            dbg_nrecords  <= dbg_nrecords + 32'd1;
                        end else begin
                            ridx         <= ridx + 2'd1;
                            m_axis_tlast <= (ridx == 2'(W_POS));
                            m_axis_tdata <= (ridx == 2'(W_QID)) ? rec_buf[W_POS] : rec_buf[W_MINVAL];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_result_collector.sv
// Self-checking bench for dtw_result_collector (FWFT FIFO model + AXIS monitor).
module tb_dtw_result_collector;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;

`ifdef DTW_RESULT_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   res_fifo_empty;
    logic [NC-1:0]   res_fifo_rden;
    logic [NC*AW-1:0] res_fifo_data;
    logic [W-1:0]    score_threshold;
    logic [AW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [1:0]      dbg_state;
    logic [SW-1:0]   dbg_sel;
    logic [31:0]     dbg_nrecords;
    logic [31:0]     dbg_ndropped;

    dtw_result_collector #(
        .NUM_CORES (NC), .AXIS_WIDTH (AW), .WIDTH (W), .SEL_WIDTH (SW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .res_fifo_empty  (res_fifo_empty),
        .res_fifo_rden   (res_fifo_rden),
        .res_fifo_data   (res_fifo_data),
        .score_threshold (score_threshold),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .dbg_state       (dbg_state),
        .dbg_sel         (dbg_sel),
        .dbg_nrecords    (dbg_nrecords),
        .dbg_ndropped    (dbg_ndropped)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tr_mode = 0;          // 0: always ready, 1: toggle, 2: never
    logic [NC-1:0] hold;

    logic [AW-1:0] fmem [NC][64];
    logic [5:0]    fhead [NC];
    logic [5:0]    ftail [NC];

    logic [AW-1:0] obs_data [128];
    logic          obs_last [128];
    int            obs_cyc  [128];
    int            nobs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [AW-1:0] w);
        fmem[c][ftail[c]] = w;
        ftail[c] = ftail[c] + 6'd1;
    endtask

    // FIFO model, tready driver and AXIS monitor, all phased off the clock edges.
    initial begin
        logic [NC-1:0] pop_mask;
        logic          prev_stall;
        logic [AW-1:0] prev_data;
        logic          prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < int'(NC); i++) begin
                res_fifo_empty[i] = hold[i] || (fhead[i] == ftail[i]);
                res_fifo_data[i*AW +: AW] = fmem[i][fhead[i]];
            end
            m_axis_tready = (tr_mode == 0) ? 1'b1 : (tr_mode == 1) ? cyc[0] : 1'b0;
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
                    chk("hold_tdata", m_axis_tdata, prev_data);
                    chk("hold_tlast", 32'(m_axis_tlast), 32'(prev_last));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    obs_data[nobs] = m_axis_tdata;
                    obs_last[nobs] = m_axis_tlast;
                    obs_cyc[nobs]  = cyc;
                    nobs++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
            #2;
            pop_mask = res_fifo_rden;
            if (rst_n && (pop_mask != '0)) begin
                chk("rden_when_empty", 32'(pop_mask & res_fifo_empty), 32'd0);
            end
            @(posedge clk);
            cyc++;
            for (int i = 0; i < int'(NC); i++) begin
                if (pop_mask[i]) fhead[i] = fhead[i] + 6'd1;
            end
        end
    end

    task automatic wait_obs(input int n, input string name);
        int k;
        k = 0;
        while (nobs < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk({name, "_timeout"}, 32'(nobs >= n), 32'd1);
    endtask

    task automatic check_rec(input int base, input string name,
                             input logic [AW-1:0] w0, input logic [AW-1:0] w1, input logic [AW-1:0] w2);
        chk({name, "_d0"}, obs_data[base],     w0);
        chk({name, "_d1"}, obs_data[base + 1], w1);
        chk({name, "_d2"}, obs_data[base + 2], w2);
        chk({name, "_l0"}, 32'(obs_last[base]),     32'd0);
        chk({name, "_l1"}, 32'(obs_last[base + 1]), 32'd0);
        chk({name, "_l2"}, 32'(obs_last[base + 2]), 32'd1);
    endtask

    typedef struct {
        int            core;
        logic [AW-1:0] w0, w1, w2;
        int            trm;
        bit            keep;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   exp_nrec, exp_ndrop, base;

        vecs[0] = '{core: 1, w0: 32'h0000_1001, w1: 32'h0000_0005, w2: 32'h0000_0000, trm: 0, keep: 1'b1};
        vecs[1] = '{core: 3, w0: 32'hDEAD_BEEF, w1: 32'hFFFF_FFFF, w2: 32'hABCD_0040, trm: 1, keep: 1'b1};
        vecs[2] = '{core: 2, w0: 32'h0000_0002, w1: 32'h0000_0003, w2: 32'h0000_0041, trm: 0, keep: !FILT};
        vecs[3] = '{core: 0, w0: 32'h0000_0007, w1: 32'h0000_0008, w2: 32'h0001_FFFF, trm: 1, keep: !FILT};
        vecs[4] = '{core: 3, w0: 32'h0000_0005, w1: 32'h0000_0006, w2: 32'h0001_0010, trm: 0, keep: 1'b1};

        rst_n           = 1'b0;
        hold            = '0;
        score_threshold = 16'h0040;
        res_fifo_empty  = '1;
        res_fifo_data   = '0;
        m_axis_tready   = 1'b0;
        for (int i = 0; i < int'(NC); i++) begin
            fhead[i] = '0;
            ftail[i] = '0;
        end
        exp_nrec  = 0;
        exp_ndrop = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_sel", 32'(dbg_sel), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_rden", 32'(res_fifo_rden), 32'd0);
        chk("rst_nrec", dbg_nrecords, 32'd0);
        chk("rst_ndrop", dbg_ndropped, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single record on core 0: latency and beat order.
        @(posedge clk); #1;
        begin
            int c0;
            c0 = cyc;
            push(0, 32'h11); push(0, 32'h2A0); push(0, 32'h0033);
            wait_obs(3, "lat");
            check_rec(0, "lat", 32'h11, 32'h2A0, 32'h0033);
            chk("lat_first", 32'(obs_cyc[0] - c0), 32'd4);
            chk("lat_last", 32'(obs_cyc[2] - c0), 32'd6);
        end
        exp_nrec = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("lat_nrec", dbg_nrecords, 32'(exp_nrec));
        chk("lat_idle", 32'(dbg_state), 32'd0);

        // Table of single records over various cores, minvals and tready patterns.
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            base    = nobs;
            tr_mode = vecs[v].trm;
            push(vecs[v].core, vecs[v].w0);
            push(vecs[v].core, vecs[v].w1);
            push(vecs[v].core, vecs[v].w2);
            if (vecs[v].keep) begin
                wait_obs(base + 3, $sformatf("vec%0d", v));
                check_rec(base, $sformatf("vec%0d", v), vecs[v].w0, vecs[v].w1, vecs[v].w2);
                exp_nrec++;
            end else begin
                exp_ndrop++;
            end
            repeat (12) @(posedge clk);
            #2;
            chk($sformatf("vec%0d_nbeats", v), 32'(nobs - base), vecs[v].keep ? 32'd3 : 32'd0);
            chk($sformatf("vec%0d_nrec", v), dbg_nrecords, 32'(exp_nrec));
            chk($sformatf("vec%0d_ndrop", v), dbg_ndropped, 32'(exp_ndrop));
            chk($sformatf("vec%0d_idle", v), 32'(dbg_state), 32'd0);
        end
        tr_mode = 0;

        // Round robin between cores 0 and 2, two records each.
        @(posedge clk); #1;
        base = nobs;
        push(0, 32'hA000_0001); push(0, 32'hA000_0002); push(0, 32'hA000_0003);
        push(0, 32'hA000_0004); push(0, 32'hA000_0005); push(0, 32'hA000_0006);
        push(2, 32'hC000_0001); push(2, 32'hC000_0002); push(2, 32'hC000_0003);
        push(2, 32'hC000_0004); push(2, 32'hC000_0005); push(2, 32'hC000_0006);
        wait_obs(base + 12, "rr");
        check_rec(base,     "rr0", 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
        check_rec(base + 3, "rr1", 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
        check_rec(base + 6, "rr2", 32'hA000_0004, 32'hA000_0005, 32'hA000_0006);
        check_rec(base + 9, "rr3", 32'hC000_0004, 32'hC000_0005, 32'hC000_0006);
        exp_nrec += 4;
        repeat (3) @(posedge clk);
        #2;
        chk("rr_nrec", dbg_nrecords, 32'(exp_nrec));

        // Core 1 runs dry after word 0; collector stays locked to it.
        @(posedge clk); #1;
        base = nobs;
        push(1, 32'h51);
        repeat (5) @(posedge clk);
        #1;
        push(0, 32'h61); push(0, 32'h62); push(0, 32'h63);
        push(3, 32'h71); push(3, 32'h72); push(3, 32'h73);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #3;
            chk("stall_state", 32'(dbg_state), 32'd1);
            chk("stall_sel", 32'(dbg_sel), 32'd1);
            chk("stall_rden", 32'(res_fifo_rden), 32'd0);
        end
        @(posedge clk); #1;
        push(1, 32'h52); push(1, 32'h53);
        wait_obs(base + 9, "stall");
        check_rec(base,     "stall1", 32'h51, 32'h52, 32'h53);
        check_rec(base + 3, "stall3", 32'h71, 32'h72, 32'h73);
        check_rec(base + 6, "stall0", 32'h61, 32'h62, 32'h63);
        exp_nrec += 3;
        repeat (3) @(posedge clk);
        #2;
        chk("stall_nrec", dbg_nrecords, 32'(exp_nrec));

        // Async reset with two words already gathered.
        @(posedge clk); #1;
        push(0, 32'h81); push(0, 32'h82);
        repeat (6) @(posedge clk);
        #2;
        chk("prerst_state", 32'(dbg_state), 32'd1);
        chk("prerst_sel", 32'(dbg_sel), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(dbg_state), 32'd0);
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_rden", 32'(res_fifo_rden), 32'd0);
        chk("midrst_nrec", dbg_nrecords, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_nrec = 0;
        @(posedge clk); #1;
        base = nobs;
        push(0, 32'h91); push(0, 32'h92); push(0, 32'h93);
        wait_obs(base + 3, "postrst");
        check_rec(base, "postrst", 32'h91, 32'h92, 32'h93);
        exp_nrec = 1;
        repeat (4) @(posedge clk);
        #2;
        chk("postrst_nbeats", 32'(nobs - base), 32'd3);
        chk("postrst_nrec", dbg_nrecords, 32'(exp_nrec));
        chk("postrst_ndrop", dbg_ndropped, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
